// File: rtl/debug_dump_sequencer.sv
// Sequences a state dump across N debug controllers on a shared frame bus,
// buffering captured frames in a small FIFO that feeds a valid/ready TX port.
module debug_dump_sequencer #(
    parameter int                  NB_CONTROL_FRAME = 32,
    parameter int                  NB_SELECT        = 6,
    parameter int                  N_CONTROLLERS    = 4,
    parameter logic [NB_SELECT-1:0] IDLE_ID         = {NB_SELECT{1'b1}},
    parameter int                  FIFO_DEPTH       = 4,
    parameter int                  NB_TIMEOUT       = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_dump_start,
    input  logic                        i_writing,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_ctrl,
    input  logic                        i_tx_ready,
    output logic [NB_SELECT-1:0]        o_request_select,
    output logic                        o_frame_valid,
    output logic [NB_CONTROL_FRAME-1:0] o_frame_to_tx,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_timeout_err,
    output logic                        o_overflow_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [NB_SELECT-1:0] LAST_IDX = NB_SELECT'(N_CONTROLLERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT_WRITE,
        S_STREAM,
        S_DRAIN,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NB_SELECT-1:0]    idx_q, idx_d;
    logic [NB_SELECT-1:0]    select_q, select_d;
    logic [NB_TIMEOUT-1:0]   tcnt_q, tcnt_d;
    logic                    done_q, done_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    overflow_err_q, overflow_err_d;
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [NB_CONTROL_FRAME-1:0] mem_q [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic wr_en;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && i_tx_ready;
    // A pop in the same cycle frees the slot, so a push while full is still kept.
    assign wr_en      = push && (!fifo_full || pop);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        select_d       = select_q;
        tcnt_d         = tcnt_q;
        done_d         = 1'b0;
        timeout_err_d  = timeout_err_q;
        overflow_err_d = overflow_err_q;
        push           = 1'b0;

        case (state_q)
            S_IDLE: begin
                select_d = IDLE_ID;
                if (i_dump_start) begin
                    timeout_err_d  = 1'b0;
                    overflow_err_d = 1'b0;
                    idx_d          = '0;
                    state_d        = S_SELECT;
                end
            end
            S_SELECT: begin
                select_d = idx_q;
                tcnt_d   = '0;
                state_d  = S_WAIT_WRITE;
            end
            S_WAIT_WRITE: begin
                if (i_writing) begin
                    push    = 1'b1;
                    state_d = S_STREAM;
                end else if (tcnt_q == {NB_TIMEOUT{1'b1}}) begin
                    timeout_err_d = 1'b1;
                    select_d      = IDLE_ID;
                    state_d       = S_GAP;
                end else begin
                    tcnt_d = tcnt_q + NB_TIMEOUT'(1);
                end
            end
            S_STREAM: begin
                if (i_writing) begin
                    push = 1'b1;
                end else begin
                    select_d = IDLE_ID;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + NB_SELECT'(1);
                    state_d = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                select_d = IDLE_ID;
                state_d  = S_IDLE;
            end
        endcase

        if (push && fifo_full && !pop) begin
            overflow_err_d = 1'b1;
        end

        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            select_q       <= IDLE_ID;
            tcnt_q         <= '0;
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            overflow_err_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            select_q       <= select_d;
            tcnt_q         <= tcnt_d;
            done_q         <= done_d;
            timeout_err_q  <= timeout_err_d;
            overflow_err_q <= overflow_err_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
        end
    end

    // Storage carries no reset; validity is defined purely by the pointers.
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_frame_from_ctrl;
        end
    end

    assign o_request_select = select_q;
    assign o_frame_valid    = !fifo_empty;
    assign o_frame_to_tx    = mem_q[rd_ptr_q[AW-1:0]];
    assign o_busy           = (state_q != S_IDLE);
    assign o_done           = done_q;
    assign o_timeout_err    = timeout_err_q;
    assign o_overflow_err   = overflow_err_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: normal dump, backpressure, overflow,
// timeout, start-while-busy and reset mid-stream.
module tb_debug_dump_sequencer;

    localparam logic [5:0] IDLE = 6'h3F;

    logic        clk;
    logic        i_reset;
    logic        i_dump_start;
    logic        i_writing;
    logic [31:0] i_frame_from_ctrl;
    logic        i_tx_ready;
    logic [5:0]  o_request_select;
    logic        o_frame_valid;
    logic [31:0] o_frame_to_tx;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout_err;
    logic        o_overflow_err;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    logic [31:0] frames[$];
    logic [5:0]  sel_log[$];
    logic [31:0] exp_frames[$];
    logic [5:0]  exp_sel[$];

    debug_dump_sequencer dut (
        .i_clock           (clk),
        .i_reset           (i_reset),
        .i_dump_start      (i_dump_start),
        .i_writing         (i_writing),
        .i_frame_from_ctrl (i_frame_from_ctrl),
        .i_tx_ready        (i_tx_ready),
        .o_request_select  (o_request_select),
        .o_frame_valid     (o_frame_valid),
        .o_frame_to_tx     (o_frame_to_tx),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_timeout_err     (o_timeout_err),
        .o_overflow_err    (o_overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observers sample on the falling edge; stimulus changes 2 units after the rising edge.
    always @(negedge clk) begin
        if (o_frame_valid === 1'b1 && i_tx_ready === 1'b1) begin
            frames.push_back(o_frame_to_tx);
            $display("tx frame %08h", o_frame_to_tx);
        end
        if (o_done === 1'b1) done_cnt++;
        if (sel_log.size() == 0 || sel_log[$] !== o_request_select)
            sel_log.push_back(o_request_select);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sel(input logic [5:0] id);
        bit ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (o_request_select === id) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check($sformatf("select_reaches_%0d", id), 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (o_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("dump_finishes", 64'(ok), 64'd1);
    endtask

    // Acts as controller `id`: waits for its select, then streams nfr frames from base.
    task automatic serve(input logic [5:0] id, input int nfr, input logic [31:0] base);
        wait_sel(id);
        for (int i = 0; i < nfr; i++) begin
            i_writing         = 1'b1;
            i_frame_from_ctrl = base + 32'(i);
            tick();
        end
        i_writing         = 1'b0;
        i_frame_from_ctrl = '0;
    endtask

    task automatic start_pulse();
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, 64'(frames.size()), 64'(exp_frames.size()));
        for (int i = 0; i < exp_frames.size() && i < frames.size(); i++)
            check($sformatf("%s_frame%0d", tag, i), 64'(frames[i]), 64'(exp_frames[i]));
    endtask

    task automatic check_sel(input string tag);
        check({tag, "_sel_len"}, 64'(sel_log.size()), 64'(exp_sel.size()));
        for (int i = 0; i < exp_sel.size() && i < sel_log.size(); i++)
            check($sformatf("%s_sel%0d", tag, i), 64'(sel_log[i]), 64'(exp_sel[i]));
    endtask

    task automatic clear_logs();
        frames.delete();
        sel_log.delete();
        exp_frames.delete();
        exp_sel.delete();
    endtask

    initial begin
        automatic int d0;
        automatic int cnt;
        i_reset           = 1'b1;
        i_dump_start      = 1'b0;
        i_writing         = 1'b0;
        i_frame_from_ctrl = '0;
        i_tx_ready        = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();

        check("rst_select",   64'(o_request_select), 64'(IDLE));
        check("rst_busy",     64'(o_busy), 64'd0);
        check("rst_done",     64'(o_done), 64'd0);
        check("rst_valid",    64'(o_frame_valid), 64'd0);
        check("rst_timeout",  64'(o_timeout_err), 64'd0);
        check("rst_overflow", 64'(o_overflow_err), 64'd0);

        // Normal dump with an ignored start pulse while busy.
        clear_logs();
        d0 = done_cnt;
        start_pulse();
        check("norm_busy", 64'(o_busy), 64'd1);
        serve(6'd0, 1, 32'hA0);
        start_pulse();
        serve(6'd1, 1, 32'hA1);
        serve(6'd2, 1, 32'hA2);
        serve(6'd3, 1, 32'hA3);
        wait_idle();
        tick();
        exp_frames = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        exp_sel    = '{IDLE, 6'd0, IDLE, 6'd1, IDLE, 6'd2, IDLE, 6'd3, IDLE};
        check_frames("norm");
        check_sel("norm");
        check("norm_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("norm_timeout", 64'(o_timeout_err), 64'd0);
        check("norm_overflow", 64'(o_overflow_err), 64'd0);

        // Backpressure on controller 0: hold in DRAIN with the idle select.
        clear_logs();
        d0 = done_cnt;
        i_tx_ready = 1'b0;
        start_pulse();
        serve(6'd0, 1, 32'hB0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("bp_hold_sel%0d", i), 64'(o_request_select), 64'(IDLE));
        end
        check("bp_valid", 64'(o_frame_valid), 64'd1);
        check("bp_head", 64'(o_frame_to_tx), 64'h0B0);
        i_tx_ready = 1'b1;
        serve(6'd1, 1, 32'hB1);
        serve(6'd2, 1, 32'hB2);
        serve(6'd3, 1, 32'hB3);
        wait_idle();
        tick();
        exp_frames = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        check_frames("bp");
        check("bp_done_pulses", 64'(done_cnt - d0), 64'd1);

        // Overflow: six frames into a four-deep FIFO with TX stalled.
        clear_logs();
        d0 = done_cnt;
        i_tx_ready = 1'b0;
        start_pulse();
        serve(6'd0, 6, 32'hC0);
        repeat (5) tick();
        check("ovf_flag", 64'(o_overflow_err), 64'd1);
        check("ovf_select_idle", 64'(o_request_select), 64'(IDLE));
        check("ovf_head", 64'(o_frame_to_tx), 64'h0C0);
        i_tx_ready = 1'b1;
        serve(6'd1, 1, 32'hD1);
        serve(6'd2, 1, 32'hD2);
        serve(6'd3, 1, 32'hD3);
        wait_idle();
        tick();
        exp_frames = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD1, 32'hD2, 32'hD3};
        check_frames("ovf");
        check("ovf_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("ovf_flag_sticky", 64'(o_overflow_err), 64'd1);
        check("ovf_no_timeout", 64'(o_timeout_err), 64'd0);

        // Timeout: controller 2 stays silent for the whole 256-cycle wait.
        clear_logs();
        d0 = done_cnt;
        start_pulse();
        check("to_start_clears_ovf", 64'(o_overflow_err), 64'd0);
        serve(6'd0, 1, 32'hF0);
        serve(6'd1, 1, 32'hF1);
        wait_sel(6'd2);
        cnt = 0;
        while (o_request_select === 6'd2 && cnt < 400) begin
            cnt++;
            tick();
        end
        check("to_wait_cycles", 64'(cnt), 64'd256);
        check("to_flag", 64'(o_timeout_err), 64'd1);
        serve(6'd3, 1, 32'hF3);
        wait_idle();
        tick();
        exp_frames = '{32'hF0, 32'hF1, 32'hF3};
        exp_sel    = '{IDLE, 6'd0, IDLE, 6'd1, IDLE, 6'd2, IDLE, 6'd3, IDLE};
        check_frames("to");
        check_sel("to");
        check("to_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("to_flag_sticky", 64'(o_timeout_err), 64'd1);

        // Next start clears the timeout flag; then reset lands mid-STREAM.
        i_tx_ready = 1'b0;
        start_pulse();
        check("restart_clears_to", 64'(o_timeout_err), 64'd0);
        d0 = done_cnt;
        wait_sel(6'd0);
        i_writing         = 1'b1;
        i_frame_from_ctrl = 32'hE0;
        tick();
        i_frame_from_ctrl = 32'hE1;
        tick();
        check("mid_valid_before_rst", 64'(o_frame_valid), 64'd1);
        i_reset = 1'b1;
        tick();
        i_reset           = 1'b0;
        i_writing         = 1'b0;
        i_frame_from_ctrl = '0;
        check("mrst_select", 64'(o_request_select), 64'(IDLE));
        check("mrst_valid",  64'(o_frame_valid), 64'd0);
        check("mrst_busy",   64'(o_busy), 64'd0);
        repeat (6) tick();
        check("mrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("mrst_stays_idle", 64'(o_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
